// File: rtl/hazard_controller_pkg.sv
// Shared definitions for the decode-side hazard controller:
// forwarding select encoding and the in-flight stage entry.
package hazard_controller_pkg;

   localparam int REG_ADDR_W = 5;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] rd;
      logic                  we;
      logic                  is_load;
   } stage_t;

   function automatic logic is_writing(stage_t e);
      return e.valid && e.we && (e.rd != '0);
   endfunction

endpackage

// File: rtl/hazard_fwd_cmp.sv
// Per-operand comparator: forwarding select for the operand entering EX,
// plus a flag when the operand depends on a load still in EX.
module hazard_fwd_cmp
   import hazard_controller_pkg::*;
(
   input  logic [REG_ADDR_W-1:0] rs,
   input  logic                  rs_used,
   input  logic                  ex_wr,
   input  logic                  ex_load,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  mem_wr,
   input  logic [REG_ADDR_W-1:0] mem_rd,
   output logic [1:0]            sel,
   output logic                  load_hit
);

   // The youngest producer (EX) shadows an older one in MEM.
   always_comb begin
      sel      = FWD_RF;
      load_hit = 1'b0;
      if (rs_used && ex_wr && (rs == ex_rd)) begin
         if (ex_load) begin
            load_hit = 1'b1;
         end else begin
            sel = FWD_MEM;
         end
      end else if (rs_used && mem_wr && (rs == mem_rd)) begin
         sel = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_controller.sv
// Load-use stall, EX bubble and registered operand forwarding selects
// for the instruction in decode of a five-stage RV32I pipeline.
module hazard_controller
   import hazard_controller_pkg::*;
#(
   parameter int PERF_W = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_rs1_used,
   input  logic                  id_rs2_used,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  id_rd_we,
   input  logic                  id_is_load,
   input  logic                  flush,
   output logic                  stall,
   output logic                  ex_bubble,
   output logic [1:0]            ex_fwd_rs1,
   output logic [1:0]            ex_fwd_rs2,
   output logic [PERF_W-1:0]     stall_count
);

   stage_t              ex_q, ex_d;
   // Past EX only "writes a nonzero rd" matters; WB producers are
   // visible through the register file, so WB needs no tracking here.
   logic                  mem_wr_q, mem_wr_d;
   logic [REG_ADDR_W-1:0] mem_rd_q, mem_rd_d;
   logic                  ex_bubble_q, ex_bubble_d;
   logic [1:0]            fwd1_q, fwd1_d;
   logic [1:0]            fwd2_q, fwd2_d;
   logic [PERF_W-1:0]     cnt_q, cnt_d;

   logic       ex_wr;
   logic [1:0] sel1, sel2;
   logic       hit1, hit2;
   logic       issue;

   assign ex_wr = is_writing(ex_q);

   hazard_fwd_cmp u_cmp_rs1 (
      .rs       (id_rs1),
      .rs_used  (id_rs1_used),
      .ex_wr    (ex_wr),
      .ex_load  (ex_q.is_load),
      .ex_rd    (ex_q.rd),
      .mem_wr   (mem_wr_q),
      .mem_rd   (mem_rd_q),
      .sel      (sel1),
      .load_hit (hit1)
   );

   hazard_fwd_cmp u_cmp_rs2 (
      .rs       (id_rs2),
      .rs_used  (id_rs2_used),
      .ex_wr    (ex_wr),
      .ex_load  (ex_q.is_load),
      .ex_rd    (ex_q.rd),
      .mem_wr   (mem_wr_q),
      .mem_rd   (mem_rd_q),
      .sel      (sel2),
      .load_hit (hit2)
   );

   assign stall = id_valid && !flush && (hit1 || hit2);
   assign issue = id_valid && !flush && !stall;

   always_comb begin
      ex_d        = '0;
      ex_bubble_d = 1'b1;
      fwd1_d      = FWD_RF;
      fwd2_d      = FWD_RF;
      if (issue) begin
         ex_d.valid   = 1'b1;
         ex_d.rd      = id_rd;
         ex_d.we      = id_rd_we;
         ex_d.is_load = id_is_load;
         ex_bubble_d  = 1'b0;
         fwd1_d       = sel1;
         fwd2_d       = sel2;
      end
      mem_wr_d = ex_wr;
      mem_rd_d = ex_q.rd;
      cnt_d    = cnt_q;
      if (stall && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ex_q        <= '0;
         mem_wr_q    <= 1'b0;
         mem_rd_q    <= '0;
         ex_bubble_q <= 1'b1;
         fwd1_q      <= FWD_RF;
         fwd2_q      <= FWD_RF;
         cnt_q       <= '0;
      end else begin
         ex_q        <= ex_d;
         mem_wr_q    <= mem_wr_d;
         mem_rd_q    <= mem_rd_d;
         ex_bubble_q <= ex_bubble_d;
         fwd1_q      <= fwd1_d;
         fwd2_q      <= fwd2_d;
         cnt_q       <= cnt_d;
      end
   end

   assign ex_bubble   = ex_bubble_q;
   assign ex_fwd_rs1  = fwd1_q;
   assign ex_fwd_rs2  = fwd2_q;
   assign stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: directed scenarios plus random traffic
// checked against a list-of-producers reference model.
module tb_hazard_controller;

   localparam int PW  = 6;
   localparam int SAT = (1 << PW) - 1;

   logic          clock = 1'b0;
   logic          reset;
   logic          id_valid;
   logic [4:0]    id_rs1, id_rs2, id_rd;
   logic          id_rs1_used, id_rs2_used;
   logic          id_rd_we, id_is_load;
   logic          flush;
   logic          stall;
   logic          ex_bubble;
   logic [1:0]    ex_fwd_rs1, ex_fwd_rs2;
   logic [PW-1:0] stall_count;

   hazard_controller #(.PERF_W(PW)) dut (
      .clock       (clock),
      .reset       (reset),
      .id_valid    (id_valid),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_rs1_used (id_rs1_used),
      .id_rs2_used (id_rs2_used),
      .id_rd       (id_rd),
      .id_rd_we    (id_rd_we),
      .id_is_load  (id_is_load),
      .flush       (flush),
      .stall       (stall),
      .ex_bubble   (ex_bubble),
      .ex_fwd_rs1  (ex_fwd_rs1),
      .ex_fwd_rs2  (ex_fwd_rs2),
      .stall_count (stall_count)
   );

   always #5 clock = ~clock;

   int errs   = 0;
   int checks = 0;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference model: pipe[0] is the producer in EX, pipe[1] in MEM.
   typedef struct {
      bit v;
      int rd;
      bit we;
      bit ld;
   } ent_t;

   ent_t pipe[2];
   int   m_cnt;
   bit   m_bub;
   int   m_f1, m_f2;

   function automatic bit wr(ent_t e);
      return e.v && e.we && (e.rd != 0);
   endfunction

   function automatic int src(int rs, bit used);
      if (!used) return 0;
      for (int a = 0; a < 2; a++) begin
         if (wr(pipe[a]) && pipe[a].rd == rs) begin
            if (a == 0) return pipe[0].ld ? 0 : 1;
            return 2;
         end
      end
      return 0;
   endfunction

   function automatic bit m_stall();
      bit h1, h2;
      h1 = id_rs1_used && (int'(id_rs1) == pipe[0].rd);
      h2 = id_rs2_used && (int'(id_rs2) == pipe[0].rd);
      return id_valid && !flush && wr(pipe[0]) && pipe[0].ld && (h1 || h2);
   endfunction

   task automatic m_reset();
      pipe[0] = '{0, 0, 0, 0};
      pipe[1] = '{0, 0, 0, 0};
      m_cnt   = 0;
      m_bub   = 1;
      m_f1    = 0;
      m_f2    = 0;
   endtask

   task automatic set_id(bit v, int rs1, bit u1, int rs2, bit u2,
                         int rd, bit we, bit ld, bit fl);
      id_valid    = v;
      id_rs1      = 5'(rs1);
      id_rs1_used = u1;
      id_rs2      = 5'(rs2);
      id_rs2_used = u2;
      id_rd       = 5'(rd);
      id_rd_we    = we;
      id_is_load  = ld;
      flush       = fl;
   endtask

   bit last_stall;

   // Called just after a negedge with inputs set; returns at the next negedge.
   task automatic cyc();
      bit s, iss;
      int f1, f2;
      #1;
      s = m_stall();
      chk("stall", stall, s);
      iss = id_valid && !flush && !s;
      f1  = iss ? src(int'(id_rs1), id_rs1_used) : 0;
      f2  = iss ? src(int'(id_rs2), id_rs2_used) : 0;
      @(posedge clock);
      pipe[1] = pipe[0];
      if (iss) pipe[0] = '{1, int'(id_rd), id_rd_we, id_is_load};
      else     pipe[0] = '{0, 0, 0, 0};
      if (s && m_cnt < SAT) m_cnt++;
      m_bub      = !iss;
      m_f1       = f1;
      m_f2       = f2;
      last_stall = s;
      #1;
      chk("ex_bubble", ex_bubble, m_bub);
      chk("fwd_rs1", ex_fwd_rs1, m_f1);
      chk("fwd_rs2", ex_fwd_rs2, m_f2);
      chk("stall_count", stall_count, m_cnt);
      @(negedge clock);
   endtask

   int cnt0;

   initial begin
      reset = 1'b1;
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
      m_reset();
      last_stall = 0;
      repeat (2) @(negedge clock);
      chk("rst_bubble", ex_bubble, 1);
      chk("rst_fwd1", ex_fwd_rs1, 0);
      chk("rst_fwd2", ex_fwd_rs2, 0);
      chk("rst_count", stall_count, 0);
      reset = 1'b0;

      // ALU add x5 then add x6,x5,x1
      set_id(1, 1, 1, 2, 1, 5, 1, 0, 0); cyc();
      set_id(1, 5, 1, 1, 1, 6, 1, 0, 0); cyc();
      chk("alu_fwd1", ex_fwd_rs1, 2'b01);
      chk("alu_fwd2", ex_fwd_rs2, 2'b00);

      // lw x7 then sub x8,x7,x7
      set_id(1, 1, 1, 0, 0, 7, 1, 1, 0); cyc();
      cnt0 = m_cnt;
      set_id(1, 7, 1, 7, 1, 8, 1, 0, 0);
      #1 chk("lu_stall", stall, 1);
      #0 cyc();
      chk("lu_bubble", ex_bubble, 1);
      cyc();
      chk("lu_fwd1", ex_fwd_rs1, 2'b10);
      chk("lu_fwd2", ex_fwd_rs2, 2'b10);
      chk("lu_count", stall_count, cnt0 + 1);

      // add x3, add x3, or x4,x3,x0: youngest wins
      set_id(1, 1, 1, 2, 1, 3, 1, 0, 0); cyc();
      set_id(1, 1, 1, 2, 1, 3, 1, 0, 0); cyc();
      set_id(1, 3, 1, 0, 1, 4, 1, 0, 0); cyc();
      chk("young_fwd1", ex_fwd_rs1, 2'b01);
      chk("x0_fwd2a", ex_fwd_rs2, 2'b00);
      // producer targeting x0 in MEM, x3 in EX
      set_id(1, 1, 1, 1, 1, 0, 1, 0, 0); cyc();
      set_id(1, 1, 1, 1, 1, 3, 1, 0, 0); cyc();
      set_id(1, 3, 1, 0, 1, 4, 1, 0, 0); cyc();
      chk("x0_fwd1", ex_fwd_rs1, 2'b01);
      chk("x0_fwd2b", ex_fwd_rs2, 2'b00);

      // load to x9 in EX, flush while decode reads x9
      set_id(1, 1, 1, 0, 0, 9, 1, 1, 0); cyc();
      cnt0 = m_cnt;
      set_id(1, 9, 1, 9, 1, 10, 1, 0, 1); cyc();
      chk("fl_bubble", ex_bubble, 1);
      chk("fl_count", stall_count, cnt0);

      // random traffic; a stalled instruction is held in decode
      for (int i = 0; i < 400; i++) begin
         if (last_stall) begin
            flush = ($urandom_range(0, 7) == 0);
         end else begin
            set_id($urandom_range(0, 7) != 0,
                   $urandom_range(0, 7), $urandom_range(0, 1),
                   $urandom_range(0, 7), $urandom_range(0, 1),
                   $urandom_range(0, 7), $urandom_range(0, 3) != 0,
                   $urandom_range(0, 2) == 0,
                   $urandom_range(0, 9) == 0);
         end
         cyc();
      end

      // mid-stream reset with a load to x5 in EX
      set_id(1, 1, 1, 0, 0, 5, 1, 1, 0); cyc();
      #2 reset = 1'b1;
      #1;
      chk("mrst_bubble", ex_bubble, 1);
      chk("mrst_fwd1", ex_fwd_rs1, 0);
      chk("mrst_fwd2", ex_fwd_rs2, 0);
      chk("mrst_count", stall_count, 0);
      m_reset();
      @(negedge clock);
      reset = 1'b0;
      set_id(1, 5, 1, 5, 1, 6, 1, 0, 0); cyc();
      chk("mrst_nostall", last_stall, 0);

      // chained lw x7,0(x7): one stall per instruction until saturation
      set_id(1, 7, 1, 0, 0, 7, 1, 1, 0);
      for (int i = 0; i < 2 * SAT + 12; i++) cyc();
      chk("sat_count", stall_count, SAT);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1);
   end

endmodule
